// File: rtl/systolic_input_skew.sv
// Left-edge feeder for the PE array: a vector FIFO followed by a diagonal
// skew pipeline. Optional macro SKEW_OCCUPANCY_EN adds a fifo_count port.
module systolic_input_skew #(
  parameter int N      = 2,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_data,
  input  logic                  in_last,
  input  logic                  in_first,
  output logic [N-1:0]          out_valid,
  output logic [N*DATA_W-1:0]   out_data,
  output logic [N-1:0]          out_switch,
  output logic                  tile_done,
  output logic                  busy
`ifdef SKEW_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0] fifo_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DC_W  = $clog2(N + 1);
  localparam int ENT_W = N * DATA_W + 2;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [DC_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic               tile_done_q, tile_done_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [ENT_W-1:0]   mem_d [DEPTH];

  logic               push, pop, fifo_empty;
  logic [ENT_W-1:0]   pop_entry;
  logic [N*DATA_W-1:0] pop_data;
  logic               pop_first, pop_last;

  // in_ready comes from the registered count only, so a full FIFO never
  // accepts a write even if a pop happens in the same cycle.
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = in_valid && in_ready;
  assign pop_entry  = mem_q[rd_ptr_q];
  assign pop_data   = pop_entry[ENT_W-1:2];
  assign pop_first  = pop_entry[1];
  assign pop_last   = pop_entry[0];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_data, in_first, in_last};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    tile_done_d = tile_done_q;
    pop         = 1'b0;
    if (enable) begin
      tile_done_d = 1'b0;
      case (state_q)
        IDLE, STREAM: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            if (pop_last) begin
              state_d     = DRAIN;
              drain_cnt_d = DC_W'(N);
            end else begin
              state_d = STREAM;
            end
          end
        end
        DRAIN: begin
          // Last element reaches lane N-1 as the count hits 1.
          if (drain_cnt_q == DC_W'(1)) begin
            tile_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      drain_cnt_q <= '0;
      tile_done_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      tile_done_q <= tile_done_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Skew pipeline: lane i is a shift register of i+1 stages; stage 0 is bit 0.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [i:0]               vld_q, vld_d, sw_q, sw_d;
    logic [(i+1)*DATA_W-1:0]  dat_q, dat_d;
    logic signed [DATA_W-1:0] dat_in;

    assign dat_in = pop ? pop_data[i*DATA_W +: DATA_W] : '0;

    if (i == 0) begin : g_head
      always_comb begin
        vld_d = vld_q;
        sw_d  = sw_q;
        dat_d = dat_q;
        if (enable) begin
          vld_d = pop;
          sw_d  = pop & pop_first;
          dat_d = dat_in;
        end
      end
    end else begin : g_tail
      always_comb begin
        vld_d = vld_q;
        sw_d  = sw_q;
        dat_d = dat_q;
        if (enable) begin
          vld_d = {vld_q[i-1:0], pop};
          sw_d  = {sw_q[i-1:0], pop & pop_first};
          dat_d = {dat_q[i*DATA_W-1:0], dat_in};
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_q <= '0;
        sw_q  <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        sw_q  <= sw_d;
        dat_q <= dat_d;
      end
    end

    assign out_valid[i]                   = vld_q[i];
    assign out_switch[i]                  = sw_q[i];
    assign out_data[i*DATA_W +: DATA_W]   = dat_q[i*DATA_W +: DATA_W];
  end

  assign tile_done = tile_done_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef SKEW_OCCUPANCY_EN
  assign fifo_count = count_q;
`endif

endmodule

// File: tb/tb_systolic_input_skew.sv
// Self-checking bench for systolic_input_skew: queue-based reference model
// compared every cycle, plus hand-computed expectations for directed cases.
module tb_systolic_input_skew;

  localparam int N      = 2;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_data = '0;
  logic                in_last = 1'b0;
  logic                in_first = 1'b0;
  logic [N-1:0]        out_valid;
  logic [N*DATA_W-1:0] out_data;
  logic [N-1:0]        out_switch;
  logic                tile_done;
  logic                busy;
`ifdef SKEW_OCCUPANCY_EN
  logic [$clog2(DEPTH):0] fifo_count;
`endif

  int errors = 0;
  int checks = 0;

  systolic_input_skew #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_first   (in_first),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_switch (out_switch),
    .tile_done  (tile_done),
    .busy       (busy)
`ifdef SKEW_OCCUPANCY_EN
    ,
    .fifo_count (fifo_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue for the FIFO and a history of what entered
  // the head of the skew (one slot per enabled cycle). Lane i shows the
  // slot pushed i enabled cycles ago.
  typedef struct packed {
    logic [N*DATA_W-1:0] d;
    logic                f;
    logic                l;
  } ent_t;

  typedef struct packed {
    logic                v;
    logic [N*DATA_W-1:0] d;
    logic                f;
  } slot_t;

  ent_t  mq[$];
  slot_t slots[$];
  int    step      = 0;
  int    last_step = -1000;
  bit    in_tile   = 1'b0;
  bit    done_exp  = 1'b0;

  always @(posedge clk or negedge rst) begin
    bit    do_push;
    ent_t  e;
    slot_t s;
    if (!rst) begin
      mq.delete();
      slots.delete();
      last_step = -1000;
      in_tile   = 1'b0;
      done_exp  = 1'b0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      if (enable) begin
        step++;
        s = '0;
        // After popping a tile's last vector, N enabled cycles pass without pops.
        if (mq.size() != 0 && step > last_step + N) begin
          e   = mq.pop_front();
          s.v = 1'b1;
          s.d = e.d;
          s.f = e.f;
          if (e.l) begin
            last_step = step;
            in_tile   = 1'b0;
          end else begin
            in_tile = 1'b1;
          end
        end
        slots.push_back(s);
        done_exp = (step == last_step + N);
      end
      if (do_push) begin
        e.d = in_data;
        e.f = in_first;
        e.l = in_last;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0]        ev, es;
    logic [N*DATA_W-1:0] ed;
    slot_t               s;
    int                  idx;
    bit                  busy_exp;
    ev = '0;
    es = '0;
    ed = '0;
    for (int i = 0; i < N; i++) begin
      idx = slots.size() - 1 - i;
      if (idx >= 0) begin
        s = slots[idx];
        ev[i] = s.v;
        es[i] = s.f;
        ed[i*DATA_W +: DATA_W] = s.d[i*DATA_W +: DATA_W];
      end
    end
    busy_exp = (mq.size() != 0) || in_tile || (step < last_step + N);
    check("out_valid",  64'(out_valid),  64'(ev));
    check("out_data",   64'(out_data),   64'(ed));
    check("out_switch", 64'(out_switch), 64'(es));
    check("tile_done",  64'(tile_done),  64'(done_exp));
    check("busy",       64'(busy),       64'(busy_exp));
    check("in_ready",   64'(in_ready),   64'(mq.size() < DEPTH));
`ifdef SKEW_OCCUPANCY_EN
    check("fifo_count", 64'(fifo_count), 64'(mq.size()));
`endif
  end

  task automatic drive(input bit v, input logic [15:0] d1, input logic [15:0] d0,
                       input bit f, input bit l);
    in_valid = v;
    in_data  = {d1, d0};
    in_first = f;
    in_last  = l;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    enable = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  bit en_tab [14] = '{1, 0, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1};

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h1);
    check("rst_busy",      64'(busy),      64'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single-vector tile, first and last
    enable = 1'b1;
    drive(1'b1, 16'h0100, 16'h0200, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_l0_valid", 64'(out_valid[0]),     64'h1);
    check("t1_l0_data",  64'(out_data[15:0]),   64'h0200);
    check("t1_l0_sw",    64'(out_switch[0]),    64'h1);
    @(negedge clk);
    check("t1_l1_valid", 64'(out_valid[1]),     64'h1);
    check("t1_l1_data",  64'(out_data[31:16]),  64'h0100);
    check("t1_l1_sw",    64'(out_switch[1]),    64'h1);
    @(negedge clk);
    check("t1_done",     64'(tile_done),        64'h1);
    check("t1_busy",     64'(busy),             64'h0);
    idle(3);

    // Three-vector tile 1.0, 2.0, 3.0
    drive(1'b1, 16'h0100, 16'h0100, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0200, 16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_l0_first", 64'({out_valid[0], out_switch[0], out_data[15:0]}), {46'h0, 2'b11, 16'h0100});
    drive(1'b1, 16'h0300, 16'h0300, 1'b0, 1'b1);
    @(negedge clk);
    check("t2_l0_second", 64'({out_switch[0], out_data[15:0]}), {47'h0, 1'b0, 16'h0200});
    check("t2_l1_first",  64'({out_switch[1], out_data[31:16]}), {47'h0, 1'b1, 16'h0100});
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_l0_third",  64'(out_data[15:0]),  64'h0300);
    check("t2_l1_second", 64'({out_switch[1], out_data[31:16]}), {47'h0, 1'b0, 16'h0200});
    @(negedge clk);
    check("t2_l1_third",  64'(out_data[31:16]), 64'h0300);
    check("t2_l0_empty",  64'(out_valid[0]),    64'h0);
    @(negedge clk);
    check("t2_done",      64'(tile_done),       64'h1);
    idle(3);

    // Fill the FIFO while frozen
    enable = 1'b0;
    drive(1'b1, 16'h0B00, 16'h0A00, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0B01, 16'h0A01, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0B02, 16'h0A02, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 16'h0B03, 16'h0A03, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_full_ready", 64'(in_ready), 64'h0);
    drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
    @(negedge clk);
    check("t3_still_full", 64'(in_ready), 64'h0);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    enable = 1'b1;
    @(negedge clk);
    check("t3_first_out", 64'({out_valid[0], out_data[15:0]}), {47'h0, 1'b1, 16'h0A00});
    idle(8);

    // Stream with enable toggling, including over the done pulse
    for (int c = 0; c < 14; c++) begin
      if (c < 3)
        drive(1'b1, 16'h1C00 + 16'(c), 16'h1D00 + 16'(c), c == 0, c == 2);
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      enable = en_tab[c];
      @(negedge clk);
    end
    idle(4);

    // Asynchronous reset in the middle of DRAIN, with a second tile queued
    drive(1'b1, 16'h0700, 16'h0600, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b1, 16'h0900, 16'h0800, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("ar_out_valid",  64'(out_valid),  64'h0);
    check("ar_out_data",   64'(out_data),   64'h0);
    check("ar_out_switch", 64'(out_switch), 64'h0);
    check("ar_tile_done",  64'(tile_done),  64'h0);
    check("ar_busy",       64'(busy),       64'h0);
    check("ar_in_ready",   64'(in_ready),   64'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
